// File: rtl/pipe_pkg.sv
// Shared types for the IF->ID pipeline stage: skid FSM states and MODE encodings.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_e;

    localparam int MODE_RIGID   = 0;
    localparam int MODE_ELASTIC = 1;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter for pipeline performance monitoring; sticks at all-ones.
module pipe_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             CLR,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (CLR) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/if_id_skid_stage.sv
// IF->ID pipeline stage: rigid single register or elastic two-entry skid buffer,
// with flush and saturating stall/bubble counters.
//
// Elastic FSM:
//   state | meaning
//   EMPTY | no valid entry, in_ready=1
//   ONE   | head valid, skid empty, in_ready=1
//   FULL  | head and skid valid, in_ready=0
module if_id_skid_stage
    import pipe_pkg::*;
#(
    parameter int IR_W  = 32,
    parameter int PC_W  = 32,
    parameter int MODE  = MODE_ELASTIC,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             CLR,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IR_W-1:0]  IR_in,
    input  logic [PC_W-1:0]  PC_in,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IR_W-1:0]  IR,
    output logic [PC_W-1:0]  PC,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    generate
        if (MODE == MODE_RIGID) begin : g_rigid
            logic            valid_q;
            logic [IR_W-1:0] ir_q;
            logic [PC_W-1:0] pc_q;

            // A bubble loads zeros so an invalid head always reads IR=PC=0.
            always_ff @(posedge clk) begin
                if (CLR || flush) begin
                    valid_q <= 1'b0;
                    ir_q    <= '0;
                    pc_q    <= '0;
                end else if (out_ready) begin
                    valid_q <= in_valid;
                    ir_q    <= in_valid ? IR_in : '0;
                    pc_q    <= in_valid ? PC_in : '0;
                end
            end

            assign in_ready  = out_ready && !CLR;
            assign out_valid = valid_q;
            assign IR        = ir_q;
            assign PC        = pc_q;
        end else begin : g_elastic
            skid_state_e     state_q, state_d;
            logic [IR_W-1:0] head_ir_q, head_ir_d, skid_ir_q, skid_ir_d;
            logic [PC_W-1:0] head_pc_q, head_pc_d, skid_pc_q, skid_pc_d;
            logic            accept, consume;

            always_ff @(posedge clk) begin
                if (CLR || flush) begin
                    state_q   <= EMPTY;
                    head_ir_q <= '0;
                    head_pc_q <= '0;
                    skid_ir_q <= '0;
                    skid_pc_q <= '0;
                end else begin
                    state_q   <= state_d;
                    head_ir_q <= head_ir_d;
                    head_pc_q <= head_pc_d;
                    skid_ir_q <= skid_ir_d;
                    skid_pc_q <= skid_pc_d;
                end
            end

            // in_ready depends only on registered state, never on out_ready.
            assign accept  = in_valid && (state_q != FULL);
            assign consume = (state_q != EMPTY) && out_ready;

            always_comb begin
                state_d   = state_q;
                head_ir_d = head_ir_q;
                head_pc_d = head_pc_q;
                skid_ir_d = skid_ir_q;
                skid_pc_d = skid_pc_q;
                case (state_q)
                    EMPTY: begin
                        if (accept) begin
                            state_d   = ONE;
                            head_ir_d = IR_in;
                            head_pc_d = PC_in;
                        end
                    end
                    ONE: begin
                        case ({accept, consume})
                            2'b10: begin
                                state_d   = FULL;
                                skid_ir_d = IR_in;
                                skid_pc_d = PC_in;
                            end
                            2'b01: begin
                                state_d   = EMPTY;
                                head_ir_d = '0;
                                head_pc_d = '0;
                            end
                            2'b11: begin
                                head_ir_d = IR_in;
                                head_pc_d = PC_in;
                            end
                            default: ;
                        endcase
                    end
                    FULL: begin
                        if (consume) begin
                            state_d   = ONE;
                            head_ir_d = skid_ir_q;
                            head_pc_d = skid_pc_q;
                            skid_ir_d = '0;
                            skid_pc_d = '0;
                        end
                    end
                    default: begin
                        state_d   = EMPTY;
                        head_ir_d = '0;
                        head_pc_d = '0;
                        skid_ir_d = '0;
                        skid_pc_d = '0;
                    end
                endcase
            end

            assign in_ready  = !CLR && (state_q != FULL);
            assign out_valid = (state_q != EMPTY);
            assign IR        = head_ir_q;
            assign PC        = head_pc_q;
        end
    endgenerate

    pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .CLR (CLR),
        .inc (out_valid && !out_ready),
        .cnt (stall_cnt)
    );

    pipe_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk (clk),
        .CLR (CLR),
        .inc (out_ready && !out_valid),
        .cnt (bubble_cnt)
    );

endmodule

// File: doc/if_id_skid_stage.md
# if_id_skid_stage

Parametrised successor to the IF→ID pipeline register. Carries instruction word and PC between fetch and decode, with a per-entry valid bit and a ready/valid handshake on both sides. Flush squashes in-flight entries. A MODE parameter selects a rigid single-register stage (stall by `out_ready`) or an elastic two-entry skid stage that breaks the combinational ready path. Saturating stall and bubble counters feed performance monitoring.

## Interface
Parameters:
- `IR_W`, 32, instruction word width
- `PC_W`, 32, PC width
- `MODE`, 1, 0 = rigid single register, 1 = elastic two-entry skid
- `CNT_W`, 16, performance counter width

Ports:
- `clk` in 1: clock; all state updates on rising edge.
- `CLR` in 1: synchronous, active-high reset.
- `in_valid` in 1: fetch presents a valid IR/PC.
- `in_ready` out 1: stage accepts this cycle.
- `IR_in` in IR_W: fetched instruction.
- `PC_in` in PC_W: fetched PC.
- `flush` in 1: branch/exception squash (synchronous).
- `out_valid` out 1: decode-side entry valid.
- `out_ready` in 1: decode consumes this cycle.
- `IR` out IR_W: head instruction.
- `PC` out PC_W: head PC.
- `stall_cnt` out CNT_W: cycles with `out_valid && !out_ready`.
- `bubble_cnt` out CNT_W: cycles with `out_ready && !out_valid`.

## Operation
- Accept = `in_valid && in_ready`. Consume = `out_valid && out_ready`.
- Priority per edge: `CLR` > `flush` > normal operation.
- `CLR`: all entries invalid, IR/PC storage = 0, both counters = 0.
- `flush`: all entries invalid, IR/PC = 0. A same-cycle accept is dropped. Counters are untouched and still count this cycle's condition.
- MODE 0 (rigid):
  - `in_ready = out_ready`, combinational.
  - On `out_ready`: `out_valid <= in_valid`, IR/PC <= inputs. A bubble loads zeros.
  - On `!out_ready`: hold all state.
- MODE 1 (elastic), states EMPTY, ONE, FULL:
  - EMPTY: accept → ONE.
  - ONE: accept without consume → FULL (new word goes to the skid entry). Consume without accept → EMPTY. Both → ONE, head replaced by input.
  - FULL: `in_ready = 0`. Consume → ONE, skid entry moves to head.
  - `in_ready = (state != FULL)`, registered. No combinational path from `out_ready` to `in_ready`.
  - Order is strictly preserved: skid entry never overtakes head.
- Invalid outputs read IR = 0 and PC = 0.
- Counters saturate at 2^CNT_W−1; they never wrap.

## Timing
- Reset values: `out_valid=0`, `IR=0`, `PC=0`, `stall_cnt=0`, `bubble_cnt=0`. `in_ready` = 0 during CLR, then 1 from the first cycle after (MODE 1), or follows `out_ready` (MODE 0).
- Latency: accept at edge N → `out_valid=1` with that data after edge N, in both modes.
- Throughput: 1 per cycle sustained in both modes when `out_ready=1`.
- MODE 1: after `out_ready` deasserts, one more word is absorbed. `in_ready` drops the cycle after FULL is reached.
- Flush at edge N: `out_valid=0` after N. `in_ready=1` after N (MODE 1).
- CLR asserted mid-transfer: entries are discarded, no partial data is presented.

## Structure
- Shared package `pipe_pkg`: state enum (EMPTY/ONE/FULL) and the MODE encoding constants (MODE_RIGID=0, MODE_ELASTIC=1).
- Sub-module `pipe_sat_counter` (CNT_W, sync CLR, inc, saturate), instantiated twice.
- Entry storage is a generate branch on MODE, in one file.

## Test plan
- CLR held 3 cycles with `in_valid=1`, IR_in=0x00000013 → `out_valid=0`, counters 0. After release (MODE 1), `in_ready=1`.
- MODE 1 streaming: PC 0x0,0x4,0x8 accepted back-to-back, `out_ready=1` → outputs in the same order, one cycle late, no bubbles counted.
- MODE 1 backpressure: `out_ready=0` after PC 0x0 is accepted; offer 0x4, 0x8 → 0x4 held in skid, `in_ready=0`, 0x8 held off. Raise `out_ready` → 0x0, 0x4, 0x8 in order. `stall_cnt` equals the low cycles.
- Flush with FULL state plus a simultaneous accept of PC 0x100 → next cycle `out_valid=0`, IR=PC=0. 0x100 never appears. Counters unchanged by the flush.
- MODE 0: `out_ready=0` for 2 cycles holds IR=0xDEADBEEF; `out_ready=1` with `in_valid=0` → `out_valid=0`, `bubble_cnt` +1.
- CNT_W=4: 20 stall cycles → `stall_cnt=15`, held there.
